// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared encodings and helpers for the data-memory arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Access sequencer states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Access owner encoding
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Starvation counter width and saturation value
    localparam int              STARVE_W   = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = 4'd15;

    // Next starvation count after an arbitration: B winning clears it,
    // B requesting and losing bumps it (saturating), otherwise it holds.
    function automatic logic [STARVE_W-1:0] starve_next(
        input logic [STARVE_W-1:0] cnt,
        input logic                b_req,
        input logic                b_won
    );
        logic [STARVE_W-1:0] nxt;
        nxt = cnt;
        if (b_won) begin
            nxt = '0;
        end else if (b_req && (cnt != STARVE_MAX)) begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_if
// Description : One requester port of the data-memory arbiter (request,
//               grant, completion and read data).
// Revision    : 1.0  initial release
// ============================================================================
interface dmem_port_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    // Requester side
    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
    );

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_pick
// Description : Winner selection between ports A and B, with a starvation
//               counter that forces B through after repeated losses.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int A_PRIORITY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic arb_en,      // arbiter is idle and may grant
    input  wire logic a_req,
    input  wire logic b_req,
    input  wire logic last_owner,  // owner of the previous grant
    output logic      any_req,
    output logic      winner       // OWNER_A / OWNER_B
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    // Pick the winner: single requester wins, ties go by starvation/priority/alternation
    always_comb begin
        any_req = a_req | b_req;
        winner  = OWNER_A;
        if (a_req && b_req) begin
            if (starve_cnt >= LIMIT) begin
                winner = OWNER_B;
            end else if (A_PRIORITY != 0) begin
                winner = OWNER_A;
            end else begin
                winner = ~last_owner;
            end
        end else if (b_req) begin
            winner = OWNER_B;
        end
    end

    // Track how many arbitrations in a row B has lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (arb_en && any_req) begin
            starve_cnt <= starve_next(starve_cnt, b_req, winner == OWNER_B);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port synchronous data memory between the
//               pipeline (A) and a loader/debug port (B). Each access runs
//               IDLE -> ACCESS -> RESP; completion pulses one cycle later.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 64,
    parameter int A_PRIORITY   = 1,
    parameter int STARVE_LIMIT = 4   // 1..15
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    dmem_port_if.slave             a,
    dmem_port_if.slave             b,
    output logic                   stall_a,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  wire logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] state;
    logic       owner;       // port that owns the access in flight
    logic       acc_we;      // access in flight is a write
    logic       last_owner;  // owner of the most recent grant
    logic       any_req;
    logic       winner;
    logic       arb_en;
    logic       grant;

    assign arb_en = (state == ST_IDLE);
    assign grant  = arb_en & any_req;

    dmem_rr_pick #(
        .A_PRIORITY   (A_PRIORITY),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_en     (arb_en),
        .a_req      (a.req),
        .b_req      (b.req),
        .last_owner (last_owner),
        .any_req    (any_req),
        .winner     (winner)
    );

    // Grants are combinational in IDLE so the requester can move on in the same cycle
    always_comb begin
        a.gnt   = grant & (winner == OWNER_A);
        b.gnt   = grant & (winner == OWNER_B);
        stall_a = a.req & ~a.done;
    end

    // Access sequencer: latch the winner's request, strobe the memory, then respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWNER_A;
            acc_we     <= 1'b0;
            last_owner <= OWNER_B;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner      <= winner;
                        last_owner <= winner;
                        acc_we     <= (winner == OWNER_B) ? b.we    : a.we;
                        mem_we     <= (winner == OWNER_B) ? b.we    : a.we;
                        mem_addr   <= (winner == OWNER_B) ? b.addr  : a.addr;
                        mem_wdata  <= (winner == OWNER_B) ? b.wdata : a.wdata;
                        mem_en     <= 1'b1;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion pulses and per-port read data; memory data is valid in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a.done  <= 1'b0;
            b.done  <= 1'b0;
            a.rdata <= '0;
            b.rdata <= '0;
        end else begin
            a.done <= (state == ST_RESP) && (owner == OWNER_A);
            b.done <= (state == ST_RESP) && (owner == OWNER_B);
            if ((state == ST_RESP) && !acc_we) begin
                if (owner == OWNER_A) begin
                    a.rdata <= mem_rdata;
                end else begin
                    b.rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed and randomized self-checking bench for dmem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_if #(.ADDR_W(8), .DATA_W(64)) pa ();
    dmem_port_if #(.ADDR_W(8), .DATA_W(64)) pb ();
    dmem_port_if #(.ADDR_W(8), .DATA_W(64)) qa ();
    dmem_port_if #(.ADDR_W(8), .DATA_W(64)) qb ();

    logic        stall_a0, mem_en0, mem_we0;
    logic [7:0]  mem_addr0;
    logic [63:0] mem_wdata0, mem_rdata0;
    logic        stall_a1, mem_en1, mem_we1;
    logic [7:0]  mem_addr1;
    logic [63:0] mem_wdata1, mem_rdata1;

    assign mem_rdata1 = 64'h0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .A_PRIORITY(1), .STARVE_LIMIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(pa), .b(pb), .stall_a(stall_a0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .A_PRIORITY(0), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(qa), .b(qb), .stall_a(stall_a1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    // Synchronous-read data memory behind dut0
    logic [63:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en0) begin
            if (mem_we0) mem[mem_addr0] <= mem_wdata0;
            mem_rdata0 <= mem[mem_addr0];
        end
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference memory image used by the transaction-level model
    logic [63:0] ref_mem [0:255];

    task automatic init_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = {32'hC0DE0000 | 32'(i), ~32'(i)};
            ref_mem[i] = {32'hC0DE0000 | 32'(i), ~32'(i)};
        end
    endtask

    task automatic clear_reqs();
        pa.req = 0; pa.we = 0; pa.addr = 0; pa.wdata = 0;
        pb.req = 0; pb.we = 0; pb.addr = 0; pb.wdata = 0;
        qa.req = 0; qa.we = 0; qa.addr = 0; qa.wdata = 0;
        qb.req = 0; qb.we = 0; qb.addr = 0; qb.wdata = 0;
    endtask

    // One isolated access on dut0: gnt in cycle 0, mem_en in 1, done in 3
    task automatic run_access(input bit on_b, input bit we, input logic [7:0] addr,
                              input logic [63:0] wdata, input logic [63:0] exp_rd,
                              input string tag);
        @(posedge clk); #1;
        if (on_b) begin
            pb.req = 1; pb.we = we; pb.addr = addr; pb.wdata = wdata;
        end else begin
            pa.req = 1; pa.we = we; pa.addr = addr; pa.wdata = wdata;
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                if (cyc == 3) begin pa.req = 0; pb.req = 0; end
            end
            @(negedge clk);
            check({tag, "_gnt"},  on_b ? pb.gnt : pa.gnt, 64'(cyc == 0));
            check({tag, "_ogn"},  on_b ? pa.gnt : pb.gnt, 64'h0);
            check({tag, "_en"},   mem_en0, 64'(cyc == 1));
            check({tag, "_we"},   mem_we0, 64'((cyc == 1) && we));
            check({tag, "_done"}, on_b ? pb.done : pa.done, 64'(cyc == 3));
            check({tag, "_stl"},  stall_a0, 64'(!on_b && (cyc < 3)));
            if (cyc == 1) check({tag, "_addr"}, mem_addr0, 64'(addr));
            if (cyc == 1 && we) check({tag, "_wdat"}, mem_wdata0, wdata);
            if (cyc == 3) check({tag, "_rd"}, on_b ? pb.rdata : pa.rdata, exp_rd);
        end
    endtask

    // Random-phase model state
    int          g_cyc;
    bit          g_b, g_we, win_b;
    logic [7:0]  g_addr;
    logic [63:0] g_wdata, g_rd, ref_ard, ref_brd;
    int          ref_starve;
    bit          a_pend, b_pend, a_sawg, b_sawg;
    bit          exp_ag, exp_bg, exp_ad, exp_bd, exp_en, exp_we;
    logic [7:0]  exp_addr;
    logic [63:0] exp_wdata;

    initial begin
        clear_reqs();
        init_mem();
        mem[3] = 64'd7;

        // Reset state
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",   {pa.gnt, pb.gnt}, 64'h0);
        check("rst_done",  {pa.done, pb.done}, 64'h0);
        check("rst_en",    {mem_en0, mem_we0}, 64'h0);
        check("rst_addr",  mem_addr0, 64'h0);
        check("rst_wdata", mem_wdata0, 64'h0);
        check("rst_ard",   pa.rdata, 64'h0);
        check("rst_brd",   pb.rdata, 64'h0);
        rst_n = 1;

        // A read, B write then A read, A write leaving a_rdata alone
        run_access(0, 0, 8'd3, 64'h0,  64'd7,  "t1");
        run_access(1, 1, 8'd5, 64'hAB, 64'h0,  "t2w");
        run_access(0, 0, 8'd5, 64'h0,  64'hAB, "t2r");
        run_access(0, 1, 8'd0, 64'h1,  64'hAB, "t6");
        check("t6_mem0", mem[0], 64'h1);

        // Reset in the middle of an A read
        @(posedge clk); #1;
        pa.req = 1; pa.we = 0; pa.addr = 8'd3;
        @(negedge clk);
        check("t5_gnt", pa.gnt, 64'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_en", mem_en0, 64'h1);
        #2;
        rst_n = 0; pa.req = 0;
        #1;
        check("t5_en0",  {mem_en0, mem_we0}, 64'h0);
        check("t5_addr", mem_addr0, 64'h0);
        check("t5_rd",   pa.rdata, 64'h0);
        check("t5_dn",   pa.done, 64'h0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_nodone", {pa.done, pb.done, mem_en0}, 64'h0);
        end
        run_access(0, 0, 8'd3, 64'h0, 64'd7, "t5n");

        // Both requesting, A priority: four A grants then B via starvation
        @(posedge clk); #1;
        pa.req = 1; pa.we = 0; pa.addr = 8'd1;
        pb.req = 1; pb.we = 0; pb.addr = 8'd2;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (k % 3 == 0) begin
                check("t3_agnt", pa.gnt, 64'((k / 3) < 4));
                check("t3_bgnt", pb.gnt, 64'((k / 3) == 4));
            end
            if (k == 12) check("t3_starve4", dut0.u_pick.starve_cnt, 64'd4);
            if (k == 13) check("t3_starve0", dut0.u_pick.starve_cnt, 64'd0);
        end
        @(posedge clk); #1;
        pa.req = 0; pb.req = 0;
        repeat (3) @(posedge clk);

        // Round-robin instance: A, B, A, B
        @(posedge clk); #1;
        qa.req = 1; qa.addr = 8'd10;
        qb.req = 1; qb.addr = 8'd20;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (k % 3 == 0) begin
                check("t4_agnt", qa.gnt, 64'(((k / 3) % 2) == 0));
                check("t4_bgnt", qb.gnt, 64'(((k / 3) % 2) == 1));
            end
            if (k % 3 == 1) begin
                check("t4_en",   mem_en1, 64'h1);
                check("t4_addr", mem_addr1, ((k / 3) % 2 == 0) ? 64'd10 : 64'd20);
            end
        end
        @(posedge clk); #1;
        qa.req = 0; qb.req = 0;
        repeat (3) @(posedge clk);

        // Randomized traffic on dut0 against a transaction-level model
        clear_reqs();
        @(negedge clk);
        rst_n = 0;
        init_mem();
        @(negedge clk);
        rst_n = 1;
        g_cyc = -10; ref_starve = 0; ref_ard = 0; ref_brd = 0;
        a_pend = 0; b_pend = 0; a_sawg = 0; b_sawg = 0;
        g_b = 0; g_we = 0; g_addr = 0; g_wdata = 0; g_rd = 0;
        for (int c = 0; c < 900; c++) begin
            @(posedge clk); #1;
            if (a_pend && a_sawg) begin a_pend = 0; pa.req = 0; end
            if (!a_pend) begin
                if ($urandom_range(0, 1) == 0) begin
                    a_pend = 1; pa.req = 1; pa.we = 1'($urandom_range(0, 1));
                    pa.addr = 8'($urandom_range(0, 7)); pa.wdata = {$urandom, $urandom};
                end
            end else if ($urandom_range(0, 19) == 0) begin
                a_pend = 0; pa.req = 0;
            end
            if (b_pend && b_sawg) begin b_pend = 0; pb.req = 0; end
            if (!b_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    b_pend = 1; pb.req = 1; pb.we = 1'($urandom_range(0, 1));
                    pb.addr = 8'($urandom_range(0, 7)); pb.wdata = {$urandom, $urandom};
                end
            end else if ($urandom_range(0, 19) == 0) begin
                b_pend = 0; pb.req = 0;
            end

            @(negedge clk);
            exp_en = 0; exp_we = 0; exp_ad = 0; exp_bd = 0;
            exp_addr = g_addr; exp_wdata = g_wdata;
            if (c == g_cyc + 1) begin exp_en = 1; exp_we = g_we; end
            if (c == g_cyc + 3) begin
                if (!g_b) begin exp_ad = 1; if (!g_we) ref_ard = g_rd; end
                else      begin exp_bd = 1; if (!g_we) ref_brd = g_rd; end
            end
            exp_ag = 0; exp_bg = 0;
            if ((c >= g_cyc + 3) && (pa.req || pb.req)) begin
                win_b = (pa.req && pb.req) ? (ref_starve >= 4) : pb.req;
                if (win_b) ref_starve = 0;
                else if (pb.req && ref_starve < 15) ref_starve++;
                exp_ag  = !win_b;
                exp_bg  = win_b;
                g_cyc   = c;
                g_b     = win_b;
                g_we    = win_b ? pb.we    : pa.we;
                g_addr  = win_b ? pb.addr  : pa.addr;
                g_wdata = win_b ? pb.wdata : pa.wdata;
                if (g_we) ref_mem[g_addr] = g_wdata;
                else      g_rd = ref_mem[g_addr];
            end
            check("rnd_agnt",  pa.gnt,   64'(exp_ag));
            check("rnd_bgnt",  pb.gnt,   64'(exp_bg));
            check("rnd_adone", pa.done,  64'(exp_ad));
            check("rnd_bdone", pb.done,  64'(exp_bd));
            check("rnd_stall", stall_a0, 64'(pa.req && !exp_ad));
            check("rnd_en",    mem_en0,  64'(exp_en));
            check("rnd_we",    mem_we0,  64'(exp_we));
            if (exp_en) check("rnd_addr", mem_addr0, 64'(exp_addr));
            if (exp_en && exp_we) check("rnd_wdata", mem_wdata0, exp_wdata);
            check("rnd_ard",   pa.rdata, ref_ard);
            check("rnd_brd",   pb.rdata, ref_brd);
            a_sawg = pa.gnt;
            b_sawg = pb.gnt;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
